mem_copy_master: RTL and testbench

//  Bus initiator for the flat simulation/SoC memory port (addr, wr_data, rd_data, we, byte_m).

---
 rtl/mem_copy_master_pkg.sv | 14 +
 rtl/mem_copy_master.sv | 143 ++++++++++++++
 tb/tb_mem_copy_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for the block copy/fill bus initiator.
package mem_copy_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int unsigned STEP_BYTE = 1;
  localparam int unsigned STEP_WORD = 2;

endpackage

// File: rtl/mem_copy_master.sv
// Block copy (read/write pairs) or block fill (write only) initiator on the flat memory port.
// state | meaning: IDLE wait for start | RD read source element | WR write destination element | FIN done pulse
module mem_copy_master
  import mem_copy_master_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fill,
  input  logic          byte_op,
  input  logic          dir,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [CW-1:0] cnt,
  input  logic [DW-1:0] fill_val,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] rem,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_we,
  output logic          mem_byte
);

  state_e        state_q;
  logic          busy_q, done_q, we_q, byte_m_q;
  logic          fill_q, byte_q, dir_q;
  logic [CW-1:0] rem_q;
  logic [AW-1:0] addr_q, src_q, dst_q;
  logic [AW-1:0] src_d, dst_d;
  logic [DW-1:0] wdata_q;

  function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] a,
                                              input logic          b,
                                              input logic          d);
    logic [AW-1:0] inc;
    inc = b ? AW'(STEP_BYTE) : AW'(STEP_WORD);
    return d ? a - inc : a + inc;
  endfunction

  assign src_d = step_addr(src_q, byte_q, dir_q);
  assign dst_d = step_addr(dst_q, byte_q, dir_q);

  // mem_wdata doubles as the data register: filled by the RD capture or the fill value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      byte_m_q <= 1'b0;
      fill_q   <= 1'b0;
      byte_q   <= 1'b0;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      wdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            fill_q   <= fill;
            byte_q   <= byte_op;
            dir_q    <= dir;
            src_q    <= src;
            dst_q    <= dst;
            rem_q    <= cnt;
            byte_m_q <= byte_op;
            if (cnt == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else if (fill) begin
              state_q <= ST_WR;
              busy_q  <= 1'b1;
              addr_q  <= dst;
              we_q    <= 1'b1;
              wdata_q <= byte_op ? DW'(fill_val[7:0]) : fill_val;
            end else begin
              state_q <= ST_RD;
              busy_q  <= 1'b1;
              addr_q  <= src;
            end
          end
        end
        ST_RD: begin
          if (abort) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_WR;
            addr_q  <= dst_q;
            we_q    <= 1'b1;
            wdata_q <= byte_q ? DW'(mem_rdata[7:0]) : mem_rdata;
          end
        end
        ST_WR: begin
          rem_q <= rem_q - 1'b1;
          src_q <= src_d;
          dst_q <= dst_d;
          if (abort || rem_q == CW'(1)) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            we_q    <= 1'b0;
          end else if (fill_q) begin
            addr_q <= dst_d;
          end else begin
            state_q <= ST_RD;
            we_q    <= 1'b0;
            addr_q  <= src_d;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rem       = rem_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_byte  = byte_m_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench: byte-array memory responder plus an element-by-element reference of copy/fill.
module tb_mem_copy_master;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          start = 1'b0, fill = 1'b0, byte_op = 1'b0, dir = 1'b0, abort = 1'b0;
  logic [AW-1:0] src = '0, dst = '0;
  logic [CW-1:0] cnt = '0;
  logic [DW-1:0] fill_val = '0;
  logic          busy, done, mem_we, mem_byte;
  logic [CW-1:0] rem;
  logic [AW-1:0] mem_addr, a_plus1;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [7:0]    dut_mem [MSZ];
  logic [7:0]    ref_mem [MSZ];
  logic          init_go = 1'b0;
  logic [AW-1:0] tr_addr [$];
  logic [DW-1:0] tr_data [$];
  logic          tr_byte [$];
  int            n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  mem_copy_master #(.AW(AW), .DW(DW), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .fill(fill), .byte_op(byte_op), .dir(dir),
    .src(src), .dst(dst), .cnt(cnt), .fill_val(fill_val), .abort(abort),
    .busy(busy), .done(done), .rem(rem), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_byte(mem_byte)
  );

  assign a_plus1   = mem_addr + 1'b1;
  assign mem_rdata = mem_byte ? {{8{dut_mem[mem_addr][7]}}, dut_mem[mem_addr]}
                              : {dut_mem[a_plus1], dut_mem[mem_addr]};

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) ^ (i >> 5) ^ 8'h5a);
  endfunction

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < MSZ; i++) dut_mem[i] <= init_byte(i);
    end else if (mem_we) begin
      dut_mem[mem_addr] <= mem_wdata[7:0];
      if (!mem_byte) dut_mem[a_plus1] <= mem_wdata[15:8];
      tr_addr.push_back(mem_addr);
      tr_data.push_back(mem_wdata);
      tr_byte.push_back(mem_byte);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // akind: 0 none, 1 abort in WR number ak, 2 abort in RD number ak, 3 reset in WR number ak
  task automatic run_cmd(input logic f, input logic b, input logic d,
                         input logic [AW-1:0] s, input logic [AW-1:0] ds,
                         input logic [CW-1:0] n, input logic [DW-1:0] fv,
                         input int akind, input int ak);
    logic [AW-1:0] e_addr [$];
    logic [DW-1:0] e_data [$];
    logic [AW-1:0] e_rd [$];
    logic [AW-1:0] obs_rd [$];
    logic [AW-1:0] sp, dp, stp, a;
    logic [DW-1:0] w;
    int m, lat, lat_obs, edges, rd_seen, wr_seen, exp_rem;
    bit got_done, got_rst;

    if (n == 0) begin
      m = 0; lat = 1;
    end else if (akind == 1 && ak < int'(n)) begin
      m = ak; lat = f ? ak + 1 : 2 * ak + 1;
    end else if (akind == 2 && !f && ak <= int'(n)) begin
      m = ak - 1; lat = 2 * ak;
    end else if (akind == 3) begin
      m = ak - 1; lat = 0;
    end else begin
      m = int'(n); lat = f ? int'(n) + 1 : 2 * int'(n) + 1;
    end
    exp_rem = (akind == 3) ? 0 : int'(n) - m;

    sp = s; dp = ds; stp = b ? AW'(1) : AW'(2);
    for (int i = 0; i < m; i++) begin
      if (f) w = fv;
      else begin
        e_rd.push_back(sp);
        a = sp + 1'b1;
        w = {ref_mem[a], ref_mem[sp]};
      end
      ref_mem[dp] = w[7:0];
      if (!b) begin a = dp + 1'b1; ref_mem[a] = w[15:8]; end
      e_addr.push_back(dp);
      e_data.push_back(w);
      sp = d ? sp - stp : sp + stp;
      dp = d ? dp - stp : dp + stp;
    end

    tr_addr.delete(); tr_data.delete(); tr_byte.delete();
    @(negedge clk);
    fill = f; byte_op = b; dir = d; src = s; dst = ds; cnt = n; fill_val = fv; start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    start = 1'b0;
    got_done = 0; got_rst = 0; rd_seen = 0; wr_seen = 0; lat_obs = 0;
    while (!got_done && !got_rst && edges < 2 * int'(n) + 10) begin
      @(negedge clk);
      if (done) begin
        got_done = 1; lat_obs = edges; start = 1'b0; abort = 1'b0;
      end else begin
        abort = 1'b0;
        fill = 1'($urandom); byte_op = 1'($urandom); dir = 1'($urandom);
        src = AW'($urandom); dst = AW'($urandom); cnt = CW'($urandom); fill_val = DW'($urandom);
        if (busy && !mem_we) begin
          obs_rd.push_back(mem_addr);
          check_eq("rd_byte", mem_byte, b);
          rd_seen++;
          if (akind == 2 && rd_seen == ak) abort = 1'b1;
        end
        if (busy && mem_we) begin
          wr_seen++;
          if (akind == 1 && wr_seen == ak) abort = 1'b1;
        end
        start = busy && ($urandom_range(0, 3) == 0);
        if (akind == 3 && busy && mem_we && wr_seen == ak) begin
          start = 1'b0;
          #2 rst = 1'b1;
          #1;
          check_eq("rst_we", mem_we, 0);
          check_eq("rst_busy", busy, 0);
          check_eq("rst_done", done, 0);
          got_rst = 1;
          @(negedge clk);
          rst = 1'b0;
        end else begin
          @(posedge clk);
          edges++;
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;

    if (akind == 3) begin
      check_eq("rst_seen", got_rst, 1);
      check_eq("no_done", got_done, 0);
      check_eq("rem_rst", rem, 0);
    end else begin
      check_eq("done_seen", got_done, 1);
      if (got_done) begin
        check_eq("latency", lat_obs, lat);
        check_eq("rem", rem, exp_rem);
        check_eq("busy_fin", busy, 0);
        @(negedge clk);
        check_eq("done_width", done, 0);
        check_eq("rem_hold", rem, exp_rem);
      end
    end
    check_eq("we_idle", mem_we, 0);

    check_eq("n_writes", tr_addr.size(), m);
    for (int i = 0; i < m && i < tr_addr.size(); i++) begin
      check_eq("wr_addr", tr_addr[i], e_addr[i]);
      check_eq("wr_byte", tr_byte[i], b);
      if (b) check_eq("wr_data", tr_data[i][7:0], e_data[i][7:0]);
      else   check_eq("wr_data", tr_data[i], e_data[i]);
    end
    for (int i = 0; i < e_rd.size(); i++) begin
      if (i < obs_rd.size()) check_eq("rd_addr", obs_rd[i], e_rd[i]);
      else check_eq("rd_count", obs_rd.size(), e_rd.size());
    end
    for (int i = 0; i < m; i++) begin
      for (int off = -1; off <= 2; off++) begin
        a = e_addr[i] + AW'(off);
        check_eq("mem", dut_mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    logic f, b, d;
    logic [AW-1:0] s, ds;
    logic [CW-1:0] n;
    int ak, akind;

    init_go = 1'b1;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);
    #1;
    check_eq("rst_busy0", busy, 0);
    check_eq("rst_done0", done, 0);
    check_eq("rst_rem0", rem, 0);
    check_eq("rst_addr0", mem_addr, 0);
    check_eq("rst_wdata0", mem_wdata, 0);
    check_eq("rst_we0", mem_we, 0);
    check_eq("rst_byte0", mem_byte, 0);
    @(posedge clk);
    #1 init_go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_we", mem_we, 0);

    run_cmd(0, 0, 0, 20'hF0000, 20'h00100, 3, 16'h0000, 0, 0);
    run_cmd(1, 1, 1, 20'h00000, 20'h00200, 4, 16'h5CA5, 0, 0);
    check_eq("fill_lo_edge", dut_mem[20'h001FC], ref_mem[20'h001FC]);
    check_eq("fill_a5", dut_mem[20'h001FD], 8'hA5);
    run_cmd(0, 0, 0, 20'h00300, 20'h00400, 0, 16'h0000, 0, 0);
    run_cmd(0, 0, 0, 20'h12340, 20'hFFFFF, 2, 16'h0000, 0, 0);
    check_eq("wrap_lo", dut_mem[20'h00000], init_byte(32'h12341));
    run_cmd(0, 0, 0, 20'h03000, 20'h04000, 10, 16'h0000, 1, 3);
    run_cmd(0, 1, 0, 20'h05000, 20'h06000, 10, 16'h0000, 2, 4);
    run_cmd(1, 0, 0, 20'h00000, 20'h07000, 8, 16'hBEEF, 1, 5);
    run_cmd(0, 1, 0, 20'h00500, 20'h00501, 6, 16'h0000, 0, 0);
    run_cmd(0, 0, 1, 20'h08000, 20'h09000, 10, 16'h0000, 3, 4);
    run_cmd(0, 0, 0, 20'h0A000, 20'h0B000, 5, 16'h0000, 0, 0);

    repeat (40) begin
      f = 1'($urandom); b = 1'($urandom); d = 1'($urandom);
      s = AW'($urandom); ds = AW'($urandom);
      if ($urandom_range(0, 3) == 0) ds = AW'(MSZ - 1 - $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) s = AW'($urandom_range(0, 3));
      n = CW'($urandom_range(0, 20));
      ak = $urandom_range(1, int'(n) + 2);
      akind = $urandom_range(0, 2);
      run_cmd(f, b, d, s, ds, n, DW'($urandom), akind, ak);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
